// File: rtl/xadc_pkg.sv
// xadc_pkg: shared DRP widths, FSM encoding and XADC register addresses
package xadc_pkg;
    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;
    localparam logic [DRP_DW-1:0] DRP_TIMEOUT_DATA = 16'hFFFF;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    localparam logic [DRP_AW-1:0] TEMP    = 7'h00;
    localparam logic [DRP_AW-1:0] VCCINT  = 7'h01;
    localparam logic [DRP_AW-1:0] VCCAUX  = 7'h02;
    localparam logic [DRP_AW-1:0] CONFIG0 = 7'h40;
    localparam logic [DRP_AW-1:0] CONFIG1 = 7'h41;
    localparam logic [DRP_AW-1:0] CONFIG2 = 7'h42;
endpackage

// File: rtl/xadc_rr_arbiter.sv
// xadc_rr_arbiter: round-robin pick of the first set request above last_grant
module xadc_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] grant_idx
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] idx;
    // scan from farthest to nearest so the requester just above last_grant wins
    always_comb begin
        any = |req;
        grant_idx = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (req[idx]) grant_idx = idx;
        end
    end
endmodule

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: shares one XADC DRP port between NREQ requesters
module xadc_drp_arbiter import xadc_pkg::*; #(
    parameter int NREQ     = 4,
    parameter int DIV_LOG2 = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [DRP_AW*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_we,
    input  logic [DRP_DW*NREQ-1:0]   req_di,
    output logic [NREQ-1:0]          done,
    output logic [DRP_DW-1:0]        rd_data,
    output logic                     err,
    output logic                     busy,
    output logic                     drp_dclk,
    output logic                     drp_den,
    output logic                     drp_dwe,
    output logic [DRP_AW-1:0]        drp_daddr,
    output logic [DRP_DW-1:0]        drp_di,
    input  logic [DRP_DW-1:0]        drp_do,
    input  logic                     drp_drdy
);
    localparam int IW = $clog2(NREQ);
    logic [DIV_LOG2-1:0] clkdiv;
    logic                tick;
    state_t              state, state_nxt;
    logic [IW-1:0]       last_grant, grant, win_idx;
    logic                any;
    logic [7:0]          tcount;
    logic                launch, finish_ok, finish_to;

    assign tick     = clkdiv == '0;
    assign drp_dclk = clkdiv[DIV_LOG2-1];

    xadc_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req),
        .last_grant(last_grant),
        .any       (any),
        .grant_idx (win_idx)
    );

    // free-running divider; its wrap to zero is the tick every DRP action aligns to
    always_ff @(posedge clock) clkdiv <= !reset_n ? '0 : clkdiv + 1'b1;

    // state register
    always_ff @(posedge clock) state <= !reset_n ? IDLE : state_nxt;

    // next state plus launch/completion strobes, evaluated only on ticks
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        if (tick && state == IDLE && any) begin
            launch    = 1'b1;
            state_nxt = WAIT;
        end else if (tick && state == WAIT) begin
            finish_ok = drp_drdy;
            finish_to = !drp_drdy && tcount == 8'(TIMEOUT);
            state_nxt = (finish_ok || finish_to) ? IDLE : WAIT;
        end
    end

    // DRP drive, timeout counting and result return to the granted requester
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done       <= '0;
            rd_data    <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            drp_daddr  <= '0;
            drp_di     <= '0;
            grant      <= '0;
            tcount     <= '0;
            last_grant <= IW'(NREQ - 1);
        end else begin
            done <= '0;
            if (launch) begin
                drp_den   <= 1'b1;
                drp_dwe   <= req_we[win_idx];
                drp_daddr <= req_addr[DRP_AW*win_idx +: DRP_AW];
                drp_di    <= req_di[DRP_DW*win_idx +: DRP_DW];
                busy      <= 1'b1;
                grant     <= win_idx;
                tcount    <= '0;
            end
            if (tick && state == WAIT) begin
                drp_den <= 1'b0;
                tcount  <= tcount + 1'b1;
            end
            if (finish_ok || finish_to) begin
                rd_data     <= finish_ok ? drp_do : DRP_TIMEOUT_DATA;
                err         <= finish_to;
                done[grant] <= 1'b1;
                busy        <= 1'b0;
                last_grant  <= grant;
            end
        end
    end
endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb_xadc_drp_arbiter: directed vectors and corner sequences for the DRP arbiter
module tb_xadc_drp_arbiter;
    import xadc_pkg::*;
    localparam int NREQ = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_we;
    logic [16*NREQ-1:0] req_di;
    logic [NREQ-1:0]   done;
    logic [15:0]       rd_data;
    logic              err, busy, drp_dclk, drp_den, drp_dwe;
    logic [6:0]        drp_daddr;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do = '0;
    logic              drp_drdy = 1'b0;

    xadc_drp_arbiter #(.NREQ(NREQ), .DIV_LOG2(3), .TIMEOUT(3)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .req_we(req_we), .req_di(req_di), .done(done), .rd_data(rd_data),
        .err(err), .busy(busy), .drp_dclk(drp_dclk), .drp_den(drp_den),
        .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // DRP stub: answers a rising DEN with DRDY held for one DCLK period
    bit          stub_en = 1'b1, stray = 1'b0, stub_den_q = 1'b0;
    int          drdy_cnt = 0;
    logic [15:0] stub_data = '0;
    always @(negedge clock) begin
        if (stub_en && drp_den && !stub_den_q) begin
            drdy_cnt = 8;
            drp_do = stub_data;
        end
        drp_drdy = (drdy_cnt > 0) || stray;
        if (drdy_cnt > 0) drdy_cnt--;
        stub_den_q = drp_den;
    end

    // independent clkdiv model: DCLK shape and DRP output change alignment
    logic [24:0] prev_drp;
    bit          mon_valid = 1'b0;
    int          phase = 0, bad_dclk = 0, bad_align = 0;
    always @(negedge clock) begin
        if (!reset_n) mon_valid = 1'b0;
        else begin
            if (!mon_valid) phase = 0;
            else begin
                phase = (phase + 1) % 8;
                if ({drp_den, drp_dwe, drp_daddr, drp_di} !== prev_drp && phase != 1) bad_align++;
            end
            if (drp_dclk !== (phase >= 4)) bad_dclk++;
            prev_drp = {drp_den, drp_dwe, drp_daddr, drp_di};
            mon_valid = 1'b1;
        end
    end

    bit          r_got, r_busy;
    logic [3:0]  r_done, r_next_done;
    logic [15:0] r_rd, r_di;
    logic        r_err, r_we;
    logic [6:0]  r_addr;
    int          r_lat, r_den_len;

    task automatic run_one(input logic [3:0] r, input logic [6:0] a, input logic w,
                           input logic [15:0] di, input logic [15:0] dv, input bit drop);
        int den_cyc;
        bit den_seen;
        den_seen = 0; den_cyc = 0; r_got = 0; r_busy = 0; r_done = '0; r_rd = '0;
        r_err = 1'b0; r_lat = 0; r_den_len = 0; r_addr = '0; r_we = 1'b0; r_di = '0;
        @(posedge clock); #1;
        req = r; req_addr = {NREQ{a}}; req_we = {NREQ{w}}; req_di = {NREQ{di}}; stub_data = dv;
        for (int c = 0; c < 600 && !r_got; c++) begin
            @(negedge clock);
            if (drp_den) begin
                r_den_len++;
                if (!den_seen) begin
                    den_seen = 1; den_cyc = cyc; r_busy = busy;
                    r_addr = drp_daddr; r_we = drp_dwe; r_di = drp_di;
                    if (drop) req = '0;
                end
            end
            if (done != 0) begin
                r_got = 1; r_done = done; r_rd = rd_data; r_err = err;
                r_lat = cyc - den_cyc; req = '0;
            end
        end
        @(negedge clock);
        r_next_done = done;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [6:0]  addr;
        logic        we;
        logic [15:0] di;
        logic [15:0] dov;
        logic [3:0]  exp_done;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs[5];

    logic [3:0] order[5];
    logic [3:0] exp_order[5];
    int n, stray_done;

    initial begin
        vecs[0] = '{4'b0001, TEMP,    1'b0, 16'h0000, 16'hA5C3, 4'b0001, 16'hA5C3};
        vecs[1] = '{4'b0100, CONFIG2, 1'b1, 16'h0400, 16'h0000, 4'b0100, 16'h0000};
        vecs[2] = '{4'b0010, VCCINT,  1'b0, 16'h0000, 16'h1234, 4'b0010, 16'h1234};
        vecs[3] = '{4'b1000, VCCAUX,  1'b0, 16'h0000, 16'h5A5A, 4'b1000, 16'h5A5A};
        vecs[4] = '{4'b0001, CONFIG0, 1'b1, 16'h8001, 16'h0F0F, 4'b0001, 16'h0F0F};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = '0; req_addr = '0; req_we = '0; req_di = '0; reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_den", drp_den, 0);
        check("rst_daddr", drp_daddr, 0);
        check("rst_rd", rd_data, 0);
        check("rst_err", err, 0);

        // contention: all four held, round-robin from requester 0
        @(posedge clock); #1;
        req = 4'hF; req_addr = {7'h03, 7'h02, 7'h01, 7'h00}; req_we = '0; stub_data = 16'h1111;
        n = 0;
        for (int c = 0; c < 2000 && n < 5; c++) begin
            @(negedge clock);
            if (done != 0) begin order[n] = done; n++; end
        end
        @(posedge clock); #1 req = '0;
        check("rr_count", n, 5);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), i < n ? order[i] : 4'h0, exp_order[i]);

        foreach (vecs[i]) begin
            run_one(vecs[i].req, vecs[i].addr, vecs[i].we, vecs[i].di, vecs[i].dov, 0);
            check($sformatf("v%0d_got", i), r_got, 1);
            check($sformatf("v%0d_done", i), r_done, vecs[i].exp_done);
            check($sformatf("v%0d_rd", i), r_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), r_err, 0);
            check($sformatf("v%0d_busy", i), r_busy, 1);
            check($sformatf("v%0d_daddr", i), r_addr, vecs[i].addr);
            check($sformatf("v%0d_dwe", i), r_we, vecs[i].we);
            check($sformatf("v%0d_di", i), r_di, vecs[i].di);
            check($sformatf("v%0d_denlen", i), r_den_len, 8);
            check($sformatf("v%0d_lat", i), r_lat, 8);
            check($sformatf("v%0d_pulse", i), r_next_done, 0);
        end

        // timeout with a silent XADC, then a normal access
        stub_en = 0;
        run_one(4'b0010, VCCAUX, 1'b0, 16'h0, 16'h0, 0);
        check("to_done", r_done, 4'b0010);
        check("to_rd", r_rd, 16'hFFFF);
        check("to_err", r_err, 1);
        check("to_lat", r_lat, 32);
        check("to_denlen", r_den_len, 8);
        check("to_pulse", r_next_done, 0);
        stub_en = 1;
        run_one(4'b0100, CONFIG1, 1'b0, 16'h0, 16'h7777, 0);
        check("after_to_done", r_done, 4'b0100);
        check("after_to_rd", r_rd, 16'h7777);
        check("after_to_err", r_err, 0);

        // reset mid-WAIT followed by a stray DRDY
        stub_en = 0;
        @(posedge clock); #1 req = 4'b0001; req_addr = {NREQ{TEMP}}; req_we = '0;
        n = 0;
        for (int c = 0; c < 100 && n == 0; c++) begin
            @(negedge clock);
            if (drp_den) n = 1;
        end
        check("rw_den_seen", n, 1);
        repeat (10) @(negedge clock);
        check("rw_busy_before", busy, 1);
        @(posedge clock); #1 req = '0; reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        check("rw_busy", busy, 0);
        check("rw_den", drp_den, 0);
        check("rw_done", done, 0);
        stray = 1; stray_done = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (done != 0 || drp_den) stray_done++;
        end
        stray = 0;
        check("stray_ignored", stray_done, 0);
        check("stray_busy", busy, 0);
        stub_en = 1;
        run_one(4'b0010, VCCINT, 1'b0, 16'h0, 16'hC0DE, 0);
        check("post_rst_done", r_done, 4'b0010);
        check("post_rst_rd", r_rd, 16'hC0DE);

        // requester drops req while its access is in flight
        run_one(4'b1000, VCCAUX, 1'b0, 16'h0, 16'h3C3C, 1);
        check("drop_done", r_done, 4'b1000);
        check("drop_rd", r_rd, 16'h3C3C);
        check("drop_err", r_err, 0);

        check("dclk_shape", bad_dclk, 0);
        check("drp_align", bad_align, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
